// File: rtl/noc_traffic_node_pkg.sv
// Shared flit layout, FSM encodings and helpers for the NoC traffic node.
package noc_traffic_node_pkg;

   localparam int unsigned NOC_DATA_WIDTH    = 32;
   localparam int unsigned NOC_ID_X_WIDTH    = 4;
   localparam int unsigned NOC_ID_Y_WIDTH    = 4;
   localparam int unsigned NOC_PATTERN_WIDTH = 16;

   // Header: {src_x, src_y, dst_x, dst_y, head tag, seq}; tail: {0, tail tag, seq}
   localparam int unsigned NOC_HEAD_SX_H = 31;
   localparam int unsigned NOC_HEAD_SX_E = 28;
   localparam int unsigned NOC_HEAD_SY_H = 27;
   localparam int unsigned NOC_HEAD_SY_E = 24;
   localparam int unsigned NOC_HEAD_DX_H = 23;
   localparam int unsigned NOC_HEAD_DX_E = 20;
   localparam int unsigned NOC_HEAD_DY_H = 19;
   localparam int unsigned NOC_HEAD_DY_E = 16;
   localparam int unsigned NOC_HEAD_H    = 15;
   localparam int unsigned NOC_HEAD_E    = 8;
   localparam int unsigned NOC_TAIL_H    = 15;
   localparam int unsigned NOC_TAIL_E    = 8;
   localparam int unsigned NOC_SEQ_H     = 7;
   localparam int unsigned NOC_SEQ_E     = 0;

   localparam logic [7:0] NOC_HEAD_TAG = 8'hA5;
   localparam logic [7:0] NOC_TAIL_TAG = 8'h5A;

   typedef enum logic [2:0] {
      SEND_IDLE,
      SEND_HEADER,
      SEND_DATA,
      SEND_TAIL,
      SEND_GAP,
      SEND_DONE
   } send_state_e;

   typedef enum logic {
      RX_IDLE,
      RX_BODY
   } rx_state_e;

   function automatic logic [NOC_DATA_WIDTH-1:0] beat_pattern(input logic [7:0] seq,
                                                              input logic [7:0] beat);
      return {(NOC_DATA_WIDTH / NOC_PATTERN_WIDTH){seq, beat}};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/noc_traffic_node_checker.sv
// Per-VC receive checker: tracks one packet at a time and flags protocol/payload errors.
module noc_traffic_checker
   import noc_traffic_node_pkg::*;
#(
   parameter int unsigned PAYLOAD_LEN = 11
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      valid_i,
   input  logic                      is_header_i,
   input  logic                      is_tail_i,
   input  logic [NOC_DATA_WIDTH-1:0] flit_i,
   output logic                      err_o,
   output logic                      tail_o
);

   rx_state_e  state_q, state_d;
   logic [7:0] seq_q, seq_d;
   logic [7:0] beat_q, beat_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RX_IDLE;
         seq_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      beat_d  = beat_q;
      err_o   = 1'b0;
      tail_o  = 1'b0;
      if (valid_i) begin
         if (is_header_i && is_tail_i) begin
            err_o   = 1'b1;
            state_d = RX_IDLE;
         end else if (is_header_i) begin
            // A header while a packet is open abandons it and restarts capture
            err_o   = (state_q == RX_BODY);
            state_d = RX_BODY;
            seq_d   = flit_i[NOC_SEQ_H:NOC_SEQ_E];
            beat_d  = '0;
         end else if (state_q == RX_IDLE) begin
            err_o = 1'b1;
         end else if (is_tail_i) begin
            tail_o  = 1'b1;
            err_o   = (beat_q != 8'(PAYLOAD_LEN)) || (flit_i[NOC_SEQ_H:NOC_SEQ_E] != seq_q);
            state_d = RX_IDLE;
         end else begin
            err_o  = (flit_i != beat_pattern(seq_q, beat_q));
            beat_d = beat_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/noc_traffic_node.sv
// NoC traffic node: packet generator with handshake-stable outputs and a per-VC receive checker.
module noc_traffic_node
   import noc_traffic_node_pkg::*;
#(
   parameter int unsigned X_ID        = 0,
   parameter int unsigned Y_ID        = 0,
   parameter int unsigned DEST_X_ID   = 0,
   parameter int unsigned DEST_Y_ID   = 0,
   parameter int unsigned VC_NUM      = 2,
   parameter int unsigned PKT_NUM     = 10,
   parameter int unsigned PAYLOAD_LEN = 11,
   parameter int unsigned GAP         = 0,
   localparam int unsigned VCW        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic                      noc_clk,
   input  logic                      noc_rst,
   input  logic                      send_en,
   output logic                      sender_valid,
   output logic                      sender_is_header,
   output logic                      sender_is_tail,
   output logic [NOC_DATA_WIDTH-1:0] sender_flit,
   output logic [VCW-1:0]            sender_vc,
   input  logic                      sender_ready,
   input  logic                      receive_valid,
   input  logic                      receive_is_header,
   input  logic                      receive_is_tail,
   input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
   input  logic [VCW-1:0]            receive_vc,
   output logic                      receive_ready,
   output logic [7:0]                send_count,
   output logic [7:0]                receive_num,
   output logic [7:0]                error_num,
   output logic                      send_done
);

   send_state_e         state_q, state_d;
   logic [7:0]          beat_q, beat_d;
   logic [15:0]         gap_q, gap_d;
   logic [7:0]          send_cnt_q, send_cnt_d;
   logic [VCW-1:0]      vc_q, vc_d;
   logic                rx_ready_q;
   logic [7:0]          rnum_q, err_q;
   logic [NOC_DATA_WIDTH-1:0] head_flit, tail_flit, data_flit;
   logic [VC_NUM-1:0]   err_vec, tail_vec;

   always_comb begin
      head_flit = '0;
      head_flit[NOC_HEAD_SX_H:NOC_HEAD_SX_E] = NOC_ID_X_WIDTH'(X_ID);
      head_flit[NOC_HEAD_SY_H:NOC_HEAD_SY_E] = NOC_ID_Y_WIDTH'(Y_ID);
      head_flit[NOC_HEAD_DX_H:NOC_HEAD_DX_E] = NOC_ID_X_WIDTH'(DEST_X_ID);
      head_flit[NOC_HEAD_DY_H:NOC_HEAD_DY_E] = NOC_ID_Y_WIDTH'(DEST_Y_ID);
      head_flit[NOC_HEAD_H:NOC_HEAD_E]       = NOC_HEAD_TAG;
      head_flit[NOC_SEQ_H:NOC_SEQ_E]         = send_cnt_q;
      tail_flit = '0;
      tail_flit[NOC_TAIL_H:NOC_TAIL_E]       = NOC_TAIL_TAG;
      tail_flit[NOC_SEQ_H:NOC_SEQ_E]         = send_cnt_q;
   end

   assign data_flit = beat_pattern(send_cnt_q, beat_q);

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         state_q    <= SEND_IDLE;
         beat_q     <= '0;
         gap_q      <= '0;
         send_cnt_q <= '0;
         vc_q       <= '0;
         rx_ready_q <= 1'b0;
         rnum_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         gap_q      <= gap_d;
         send_cnt_q <= send_cnt_d;
         vc_q       <= vc_d;
         rx_ready_q <= 1'b1;
         if (|tail_vec) rnum_q <= sat_inc(rnum_q);
         if (|err_vec)  err_q  <= sat_inc(err_q);
      end
   end

   // Outputs depend only on registered state, so they hold while stalled
   always_comb begin
      state_d          = state_q;
      beat_d           = beat_q;
      gap_d            = gap_q;
      send_cnt_d       = send_cnt_q;
      vc_d             = vc_q;
      sender_valid     = 1'b0;
      sender_is_header = 1'b0;
      sender_is_tail   = 1'b0;
      sender_flit      = '0;
      case (state_q)
         SEND_IDLE: begin
            if (send_cnt_q == 8'(PKT_NUM)) state_d = SEND_DONE;
            else if (send_en)              state_d = SEND_HEADER;
         end
         SEND_HEADER: begin
            sender_valid     = 1'b1;
            sender_is_header = 1'b1;
            sender_flit      = head_flit;
            if (sender_ready) begin
               state_d = SEND_DATA;
               beat_d  = '0;
            end
         end
         SEND_DATA: begin
            sender_valid = 1'b1;
            sender_flit  = data_flit;
            if (sender_ready) begin
               if (beat_q == 8'(PAYLOAD_LEN - 1)) state_d = SEND_TAIL;
               else                               beat_d  = beat_q + 8'd1;
            end
         end
         SEND_TAIL: begin
            sender_valid   = 1'b1;
            sender_is_tail = 1'b1;
            sender_flit    = tail_flit;
            if (sender_ready) begin
               send_cnt_d = sat_inc(send_cnt_q);
               vc_d       = (vc_q == VCW'(VC_NUM - 1)) ? '0 : vc_q + VCW'(1);
               gap_d      = '0;
               state_d    = (GAP == 0) ? SEND_IDLE : SEND_GAP;
            end
         end
         SEND_GAP: begin
            if (gap_q == 16'(GAP - 1)) state_d = SEND_IDLE;
            else                       gap_d   = gap_q + 16'd1;
         end
         SEND_DONE: ;
         default: state_d = SEND_IDLE;
      endcase
   end

   assign sender_vc     = vc_q;
   assign send_count    = send_cnt_q;
   assign send_done     = (state_q == SEND_DONE);
   assign receive_ready = rx_ready_q;
   assign receive_num   = rnum_q;
   assign error_num     = err_q;

   for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
      noc_traffic_checker #(
         .PAYLOAD_LEN (PAYLOAD_LEN)
      ) u_checker (
         .clk_i       (noc_clk),
         .rst_i       (noc_rst),
         .valid_i     (receive_valid && rx_ready_q && (receive_vc == VCW'(g))),
         .is_header_i (receive_is_header),
         .is_tail_i   (receive_is_tail),
         .flit_i      (receive_flit),
         .err_o       (err_vec[g]),
         .tail_o      (tail_vec[g])
      );
   end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: flit-stream / per-VC receive model plus loopback and injection scenarios.
module tb_noc_traffic_node;

   localparam int unsigned PL  = 4;
   localparam int unsigned PKT = 3;
   localparam int unsigned VCN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: VC_NUM=2, PKT_NUM=3, PAYLOAD_LEN=4, GAP=0
   logic        rst_a, send_en_a, loop_a, rdy_a;
   logic        s_valid_a, s_hdr_a, s_tl_a, s_ready_a;
   logic [31:0] s_flit_a;
   logic [0:0]  s_vc_a;
   logic        r_valid_a, r_hdr_a, r_tl_a, r_ready_a;
   logic [31:0] r_flit_a;
   logic [0:0]  r_vc_a;
   logic [7:0]  cnt_a, rnum_a, err_a;
   logic        done_a;
   logic        inj_valid, inj_hdr, inj_tl;
   logic [31:0] inj_flit;
   logic [0:0]  inj_vc;

   assign s_ready_a = rdy_a & r_ready_a;
   assign r_valid_a = loop_a ? (s_valid_a & rdy_a) : inj_valid;
   assign r_hdr_a   = loop_a ? s_hdr_a  : inj_hdr;
   assign r_tl_a    = loop_a ? s_tl_a   : inj_tl;
   assign r_flit_a  = loop_a ? s_flit_a : inj_flit;
   assign r_vc_a    = loop_a ? s_vc_a   : inj_vc;

   noc_traffic_node #(
      .X_ID(1), .Y_ID(2), .DEST_X_ID(3), .DEST_Y_ID(4),
      .VC_NUM(VCN), .PKT_NUM(PKT), .PAYLOAD_LEN(PL), .GAP(0)
   ) u_dut_a (
      .noc_clk(clk), .noc_rst(rst_a), .send_en(send_en_a),
      .sender_valid(s_valid_a), .sender_is_header(s_hdr_a), .sender_is_tail(s_tl_a),
      .sender_flit(s_flit_a), .sender_vc(s_vc_a), .sender_ready(s_ready_a),
      .receive_valid(r_valid_a), .receive_is_header(r_hdr_a), .receive_is_tail(r_tl_a),
      .receive_flit(r_flit_a), .receive_vc(r_vc_a), .receive_ready(r_ready_a),
      .send_count(cnt_a), .receive_num(rnum_a), .error_num(err_a), .send_done(done_a)
   );

   // DUT B: VC_NUM=4, PKT_NUM=8, PAYLOAD_LEN=2, GAP=3, loopback
   logic        rst_b, send_en_b, rdy_b;
   logic        s_valid_b, s_hdr_b, s_tl_b, s_ready_b, r_ready_b, r_valid_b;
   logic [31:0] s_flit_b;
   logic [1:0]  s_vc_b;
   logic [7:0]  cnt_b, rnum_b, err_b;
   logic        done_b;

   assign s_ready_b = rdy_b & r_ready_b;
   assign r_valid_b = s_valid_b & rdy_b;

   noc_traffic_node #(
      .X_ID(2), .Y_ID(1), .DEST_X_ID(0), .DEST_Y_ID(3),
      .VC_NUM(4), .PKT_NUM(8), .PAYLOAD_LEN(2), .GAP(3)
   ) u_dut_b (
      .noc_clk(clk), .noc_rst(rst_b), .send_en(send_en_b),
      .sender_valid(s_valid_b), .sender_is_header(s_hdr_b), .sender_is_tail(s_tl_b),
      .sender_flit(s_flit_b), .sender_vc(s_vc_b), .sender_ready(s_ready_b),
      .receive_valid(r_valid_b), .receive_is_header(s_hdr_b), .receive_is_tail(s_tl_b),
      .receive_flit(s_flit_b), .receive_vc(s_vc_b), .receive_ready(r_ready_b),
      .send_count(cnt_b), .receive_num(rnum_b), .error_num(err_b), .send_done(done_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] hdr_flit(int sx, int sy, int dx, int dy, int seq);
      return (32'(sx) << 28) | (32'(sy) << 24) | (32'(dx) << 20) | (32'(dy) << 16)
           | 32'h0000_A500 | 32'(seq & 255);
   endfunction

   function automatic logic [31:0] data_flit(int seq, int k);
      logic [15:0] h;
      h = {8'(seq), 8'(k)};
      return {h, h};
   endfunction

   function automatic logic [31:0] tail_flit(int seq);
      return 32'h0000_5A00 | 32'(seq & 255);
   endfunction

   // Sender reference: packet p, position 0 = header, 1..PL = data, PL+1 = tail
   function automatic logic [31:0] exp_flit(int p, int pos);
      if (pos == 0)       return hdr_flit(1, 2, 3, 4, p);
      else if (pos <= PL) return data_flit(p, pos - 1);
      else                return tail_flit(p);
   endfunction

   int m_p = 0, m_pos = 0, m_xfers = 0, m_rnum = 0, m_err = 0;
   bit m_busy [VCN];
   int m_seq  [VCN];
   int m_beats[VCN];
   bit m_ready = 1'b0;
   bit rst_seen = 1'b1;
   bit stall_prev = 1'b0;
   logic [31:0] prev_flit;
   logic [3:0]  prev_ctl;
   int ncyc = 0;

   function automatic int sat(int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   function automatic void model_reset();
      m_p = 0; m_pos = 0; m_xfers = 0; m_rnum = 0; m_err = 0;
      for (int i = 0; i < VCN; i++) begin
         m_busy[i] = 1'b0; m_seq[i] = 0; m_beats[i] = 0;
      end
   endfunction

   function automatic void rx_model(int vc, bit h, bit t, logic [31:0] f);
      if (h && t) begin
         m_err = sat(m_err); m_busy[vc] = 1'b0;
      end else if (h) begin
         if (m_busy[vc]) m_err = sat(m_err);
         m_busy[vc] = 1'b1; m_seq[vc] = int'(f[7:0]); m_beats[vc] = 0;
      end else if (!m_busy[vc]) begin
         m_err = sat(m_err);
      end else if (t) begin
         m_rnum = sat(m_rnum);
         if (m_beats[vc] != PL || int'(f[7:0]) != m_seq[vc]) m_err = sat(m_err);
         m_busy[vc] = 1'b0;
      end else begin
         if (f !== data_flit(m_seq[vc], m_beats[vc])) m_err = sat(m_err);
         m_beats[vc]++;
      end
   endfunction

   always @(posedge clk) ncyc <= ncyc + 1;

   // Compare DUT A to the model, then apply the events that the next edge will see
   always @(negedge clk) begin
      if (ncyc > 0) begin
         chk("receive_ready", r_ready_a, m_ready);
         chk("send_count", cnt_a, m_p);
         chk("receive_num", rnum_a, m_rnum);
         chk("error_num", err_a, m_err);
         if (rst_seen) begin
            chk("rst_out_ctl", {s_valid_a, s_hdr_a, s_tl_a, s_vc_a, done_a}, 0);
            chk("rst_out_flit", s_flit_a, 0);
         end else if (stall_prev) begin
            chk("hold_flit", s_flit_a, prev_flit);
            chk("hold_ctl", {s_valid_a, s_hdr_a, s_tl_a, s_vc_a}, prev_ctl);
         end
         if (done_a) begin
            chk("done_pkts", m_p, PKT);
            chk("done_idle", s_valid_a, 0);
         end
         if (rst_a) begin
            model_reset();
            m_ready = 1'b0; rst_seen = 1'b1; stall_prev = 1'b0;
         end else begin
            rst_seen = 1'b0;
            if (s_valid_a && s_ready_a) begin
               if (m_p >= PKT) chk("extra_xfer", s_valid_a, 0);
               else begin
                  chk("xfer_flit", s_flit_a, exp_flit(m_p, m_pos));
                  chk("xfer_hdr", s_hdr_a, m_pos == 0);
                  chk("xfer_tail", s_tl_a, m_pos == PL + 1);
                  chk("xfer_vc", s_vc_a, m_p % VCN);
                  m_xfers++;
                  if (m_pos == PL + 1) begin m_pos = 0; m_p++; end
                  else m_pos++;
               end
            end
            stall_prev = s_valid_a && !s_ready_a;
            prev_flit  = s_flit_a;
            prev_ctl   = {s_valid_a, s_hdr_a, s_tl_a, s_vc_a};
            if (r_valid_a && m_ready) rx_model(int'(r_vc_a), r_hdr_a, r_tl_a, r_flit_a);
            m_ready = 1'b1;
         end
      end
   end

   // DUT B header monitor: records the VC of each packet
   int nb = 0;
   logic [1:0] b_vcs [8];
   always @(negedge clk) begin
      if (!rst_b && s_valid_b && s_ready_b && s_hdr_b) begin
         chk("b_hdr_flit", s_flit_b, hdr_flit(2, 1, 0, 3, nb));
         if (nb < 8) b_vcs[nb] = s_vc_b;
         nb++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic inj(input int vc, input bit h, input bit t, input logic [31:0] f);
      inj_valid = 1'b1; inj_hdr = h; inj_tl = t; inj_flit = f; inj_vc = 1'(vc);
      tick();
   endtask

   task automatic restart_a();
      rst_a = 1'b1;
      tick(2);
      rst_a = 1'b0;
   endtask

   task automatic wait_done_a(input int lim, input int mode);
      for (int i = 0; i < lim && !done_a; i++) begin
         if (mode == 1) rdy_a = ~rdy_a;
         if (mode == 2) begin
            rdy_a     = ($urandom_range(0, 3) != 0);
            send_en_a = ($urandom_range(0, 3) != 0);
         end
         tick();
      end
      chk("done_reached", done_a, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_vc [8];
      exp_vc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      rst_a = 1'b1; send_en_a = 1'b0; loop_a = 1'b1; rdy_a = 1'b0;
      inj_valid = 1'b0; inj_hdr = 1'b0; inj_tl = 1'b0; inj_flit = '0; inj_vc = '0;
      rst_b = 1'b1; send_en_b = 1'b0; rdy_b = 1'b0;
      tick(3);
      chk("rst_ready", r_ready_a, 0);
      chk("rst_counters", {cnt_a, rnum_a, err_a}, 0);

      // Loopback, ready always high
      rst_a = 1'b0; rdy_a = 1'b1; send_en_a = 1'b1;
      for (int i = 0; i < 10 && !s_valid_a; i++) tick();
      chk("lit_header0", s_flit_a, 32'h1234_A500);
      wait_done_a(200, 0);
      chk("lit_xfers", m_xfers, 18);
      chk("lit_rnum", rnum_a, 3);
      chk("lit_err", err_a, 0);
      chk("lit_send_count", cnt_a, 3);

      // Loopback with ready toggling every cycle
      restart_a();
      wait_done_a(400, 1);
      chk("toggle_rnum", rnum_a, 3);
      chk("toggle_err", err_a, 0);

      // Random stall/enable, reset mid-DATA of packet 1, then full rerun
      restart_a();
      for (int i = 0; i < 300 && !(m_p == 1 && m_pos == 2); i++) begin
         rdy_a = ($urandom_range(0, 1) != 0);
         tick();
      end
      chk("mid_pkt_reached", m_pos, 2);
      rst_a = 1'b1;
      tick();
      chk("mid_rst_valid", s_valid_a, 0);
      chk("mid_rst_cnt", cnt_a, 0);
      rst_a = 1'b0;
      wait_done_a(800, 2);
      chk("rerun_rnum", rnum_a, 3);
      chk("rerun_err", err_a, 0);

      // Injection: early tail after 2 data beats
      rdy_a = 1'b1; send_en_a = 1'b0; loop_a = 1'b0;
      restart_a();
      tick();
      inj(0, 1, 0, hdr_flit(1, 2, 3, 4, 5));
      inj(0, 0, 0, data_flit(5, 0));
      inj(0, 0, 0, data_flit(5, 1));
      inj(0, 0, 1, tail_flit(5));
      inj_valid = 1'b0;
      tick();
      chk("short_err", err_a, 1);
      chk("short_rnum", rnum_a, 1);

      // Corrupted beat 1 low byte, then data on an idle VC
      restart_a();
      tick();
      inj(1, 1, 0, hdr_flit(1, 2, 3, 4, 7));
      inj(1, 0, 0, data_flit(7, 0));
      inj(1, 0, 0, data_flit(7, 1) ^ 32'h0000_00FF);
      inj(1, 0, 0, data_flit(7, 2));
      inj(1, 0, 0, data_flit(7, 3));
      inj(1, 0, 1, tail_flit(7));
      inj_valid = 1'b0;
      tick();
      chk("corrupt_err", err_a, 1);
      chk("corrupt_rnum", rnum_a, 1);
      inj(0, 0, 0, data_flit(7, 0));
      inj_valid = 1'b0;
      tick();
      chk("idle_vc_err", err_a, 2);
      inj(1, 1, 1, 32'h0);
      inj_valid = 1'b0;
      tick();
      chk("hdr_tail_err", err_a, 3);

      // Random flit soup against the receive model
      for (int i = 0; i < 120; i++) begin
         int vc;
         bit h, t;
         logic [31:0] f;
         vc = $urandom_range(0, VCN - 1);
         h  = ($urandom_range(0, 4) == 0);
         t  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) f = $urandom;
         else if (h)                    f = hdr_flit(1, 2, 3, 4, $urandom_range(0, 255));
         else if (t)                    f = tail_flit(m_seq[vc]);
         else                           f = data_flit(m_seq[vc], m_beats[vc]);
         inj_valid = ($urandom_range(0, 4) != 0);
         inj_hdr = h; inj_tl = t; inj_flit = f; inj_vc = 1'(vc);
         tick();
      end
      inj_valid = 1'b0;
      tick();

      // Error counter saturation
      restart_a();
      tick();
      inj_valid = 1'b1; inj_hdr = 1'b0; inj_tl = 1'b0; inj_vc = '0; inj_flit = 32'h1;
      tick(260);
      inj_valid = 1'b0;
      tick();
      chk("err_saturate", err_a, 255);

      // DUT B: four VCs round-robin, gapped packets, random stalls
      tick(2);
      rst_b = 1'b0; send_en_b = 1'b1;
      for (int i = 0; i < 1500 && !done_b; i++) begin
         rdy_b = ($urandom_range(0, 2) != 0);
         tick();
      end
      rdy_b = 1'b1;
      tick(2);
      chk("b_done", done_b, 1);
      chk("b_send_count", cnt_b, 8);
      chk("b_rnum", rnum_b, 8);
      chk("b_err", err_b, 0);
      chk("b_headers", nb, 8);
      for (int i = 0; i < 8; i++) chk("b_vc_seq", b_vcs[i], exp_vc[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
